// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter and its consumers.
package cdb_arbiter_pkg;

    // Number of requesters on the bus: 0=ALU, 1=MUL, 2=DIV, 3=LSQ.
    localparam int CDB           = 4;
    localparam int CDB_PORTS     = 2;
    localparam int CDB_PAYLOAD_W = 32;

    // Index width that stays legal even for a single-entry vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(CDB)-1:0]   cdb_src_t;
    typedef logic [CDB_PAYLOAD_W-1:0] fu_output_t;

    // One broadcast port as seen by ROB, register file and wakeup logic.
    typedef struct packed {
        logic       valid;
        cdb_src_t   src;
        fu_output_t payload;
    } cdb_bcast_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester handshake and broadcast bus between functional units and the CDB arbiter.
interface cdb_arbiter_if #(
    parameter int N_REQ     = cdb_arbiter_pkg::CDB,
    parameter int N_PORTS   = cdb_arbiter_pkg::CDB_PORTS,
    parameter int PAYLOAD_W = cdb_arbiter_pkg::CDB_PAYLOAD_W
);
    localparam int SRC_W = cdb_arbiter_pkg::idx_w(N_REQ);

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ*PAYLOAD_W-1:0]   req_data;
    logic [N_REQ-1:0]             req_ready;
    logic [N_PORTS-1:0]           cdb_valid;
    logic [N_PORTS*PAYLOAD_W-1:0] cdb_data;
    logic [N_PORTS*SRC_W-1:0]     cdb_src;

    // Functional-unit side: presents results, watches the broadcast.
    modport master (
        output req_valid, req_data,
        input  req_ready, cdb_valid, cdb_data, cdb_src
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data,
        output req_ready, cdb_valid, cdb_data, cdb_src
    );

endinterface

// File: rtl/cdb_rr_picker.sv
// Combinational rotating-priority picker: grants up to N_PORTS set bits of
// hold_v, scanning upward from rr_ptr, and returns the pointer just past the
// last grant. Shared with reservation-station issue select.
module cdb_rr_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ   = CDB,
    parameter int N_PORTS = CDB_PORTS,
    localparam int SRC_W  = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0]              hold_v,
    input  logic [SRC_W-1:0]              rr_ptr,
    output logic [N_PORTS-1:0][N_REQ-1:0] grant,
    output logic [SRC_W-1:0]              next_ptr
);

    int n_granted;
    int idx;

    // Walk the requesters in rotated order; the k-th hit goes to port k.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        grant     = '0;
        next_ptr  = rr_ptr;
        n_granted = 0;
        idx       = 0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (int'(rr_ptr) + off) % N_REQ;
            if (hold_v[idx] && (n_granted < N_PORTS)) begin
                grant[n_granted][idx] = 1'b1;
                next_ptr              = SRC_W'((idx + 1) % N_REQ);
                n_granted             = n_granted + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one-entry holding register per functional unit, round-robin
// selection of up to N_PORTS held results per cycle, registered broadcast.
// Optional build macro CDB_ARB_PERF_EN adds saturating stall/broadcast counters.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ     = CDB,
    parameter int N_PORTS   = CDB_PORTS,
    parameter int PAYLOAD_W = CDB_PAYLOAD_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [N_REQ*16-1:0] perf_stall,
    output logic [31:0]         perf_bcast
`endif
);

    localparam int SRC_W = idx_w(N_REQ);

    logic [N_REQ-1:0]                 hold_v;
    logic [PAYLOAD_W-1:0]             hold_data [N_REQ];
    logic [SRC_W-1:0]                 rr_ptr;
    logic [SRC_W-1:0]                 next_ptr;
    logic [N_PORTS-1:0][N_REQ-1:0]    port_grant;
    logic [N_REQ-1:0]                 req_grant;
    logic [N_REQ-1:0]                 accept;
    logic [N_PORTS-1:0]               port_busy;
    logic [N_PORTS-1:0][PAYLOAD_W-1:0] sel_data;
    logic [N_PORTS-1:0][SRC_W-1:0]    sel_src;

    cdb_rr_picker #(
        .N_REQ   (N_REQ),
        .N_PORTS (N_PORTS)
    ) u_picker (
        .hold_v   (hold_v),
        .rr_ptr   (rr_ptr),
        .grant    (port_grant),
        .next_ptr (next_ptr)
    );

    // Fold per-port grants into per-requester grants and steer payloads onto ports.
    always_comb begin
        req_grant = '0;
        port_busy = '0;
        sel_data  = '0;
        sel_src   = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            port_busy[p] = |port_grant[p];
            for (int i = 0; i < N_REQ; i++) begin
                if (port_grant[p][i]) begin
                    req_grant[i] = 1'b1;
                    sel_data[p]  = hold_data[i];
                    sel_src[p]   = SRC_W'(i);
                end
            end
        end
    end

    // A slot is free when empty or being drained this cycle; never looks at req_valid.
    assign bus.req_ready = ~hold_v | req_grant;
    assign accept        = bus.req_valid & bus.req_ready;

    // Holding-register occupancy: drain on grant, refill on accept, flush empties all.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            hold_v <= '0;
        end else if (flush) begin
            hold_v <= '0;
        end else begin
            hold_v <= (hold_v & ~req_grant) | accept;
        end
    end

    // Holding-register payloads.
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; hold_v alone decides whether an entry is live.
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i]) begin
                hold_data[i] <= bus.req_data[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // Round-robin pointer: moves past the last grant, frozen on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (!flush) begin
            rr_ptr <= next_ptr;
        end
    end

    // Registered broadcast; idle ports keep their last data/src.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cdb_valid <= '0;
            bus.cdb_data  <= '0;
            bus.cdb_src   <= '0;
        end else if (flush) begin
            bus.cdb_valid <= '0;
        end else begin
            bus.cdb_valid <= port_busy;
            for (int p = 0; p < N_PORTS; p++) begin
                if (port_busy[p]) begin
                    bus.cdb_data[p*PAYLOAD_W +: PAYLOAD_W] <= sel_data[p];
                    bus.cdb_src[p*SRC_W +: SRC_W]          <= sel_src[p];
                end
            end
        end
    end

`ifdef CDB_ARB_PERF_EN
    logic [N_REQ-1:0] stall_now;
    logic [32:0]      bcast_sum;

    // Per-cycle stall mask and widened broadcast sum for saturation.
    always_comb begin
        stall_now = bus.req_valid & ~bus.req_ready;
        bcast_sum = {1'b0, perf_bcast} + 33'($countones(port_busy));
    end

    // Saturating performance counters; survive flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= '0;
            perf_bcast <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (stall_now[i] && (perf_stall[i*16 +: 16] != 16'hFFFF)) begin
                    perf_stall[i*16 +: 16] <= perf_stall[i*16 +: 16] + 16'd1;
                end
            end
            if (!flush) begin
                perf_bcast <= bcast_sum[32] ? 32'hFFFF_FFFF : bcast_sum[31:0];
            end
        end
    end
`endif

endmodule
